softmax_max_subtract: RTL and testbench
=======================================

SOFTMAX_MAX_SUBTRACT -- requirements
Module: softmax_max_subtract

Interface
REQ-001 Parameter LEN, default 16, sets the data width in bits (two's-complement signed).
REQ-002 Parameter DEPTH, default 16, sets the maximum vector length; it SHALL be 2..256; AW = clog2(DEPTH).
REQ-003 clk  input  1  the single clock; all state SHALL change on the rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 in_valid  input  1  the in_data/in_last beat is valid.
REQ-006 in_ready  output  1  the block accepts a beat; a beat transfers when in_valid && in_ready.
REQ-007 in_data  input  LEN  signed score element.
REQ-008 in_last  input  1  marks the final element of the vector.
REQ-009 out_valid  output  1  the out_angle/out_last beat is valid.
REQ-010 out_ready  input  1  the downstream exp stage accepts; a beat transfers when out_valid && out_ready.
REQ-011 out_angle  output  LEN  signed value (element minus vector max), saturated, always <= 0.
REQ-012 out_last  output  1  marks the final output element of the vector.
REQ-013 err  output  1  sticky overflow flag; set when a vector is truncated at DEPTH.

Function
REQ-014 The block SHALL have two states: LOAD and EMIT.
REQ-015 LOAD behaviour:
- in_ready=1 and out_valid=0.
- Each accepted beat SHALL be written to buf[cnt]; cnt increments.
- Running max SHALL update to max(max, in_data), signed compare.
REQ-016 The running-max compare SHALL include the element accepted in the same cycle, so the stored max equals the true vector max.
REQ-017 Accepting a beat with in_last=1 SHALL switch the state to EMIT on that edge; len is latched as cnt+1 and the read index rd is cleared to 0.
REQ-018 Accepting a beat at cnt==DEPTH-1 with in_last=0 SHALL treat that beat as last:
- the state switches to EMIT as in REQ-017;
- err is set to 1;
- input beats after that point SHALL be refused until the state returns to LOAD.
REQ-019 EMIT behaviour:
- in_ready=0 and out_valid=1.
- out_angle = sat(buf[rd] - max), computed at LEN+1 bits and clamped to -2^(LEN-1) when the result is below that value.
- out_last = (rd == len-1).
REQ-020 Latency: out_valid SHALL rise on the first edge after the last input beat is accepted; the output SHALL then sustain one beat per cycle while out_ready=1.
REQ-021 While out_valid=1 and out_ready=0, out_angle and out_last SHALL hold stable.
REQ-022 A transfer with out_last=1 SHALL return the state to LOAD on that edge and clear cnt and rd; max is reset to -2^(LEN-1). The next input beat is accepted in the following cycle (no overlap of EMIT and LOAD).
REQ-023 A single-element vector SHALL produce one output of 0 with out_last=1.
REQ-024 Equal elements SHALL each produce 0; the element equal to max SHALL produce exactly 0.
REQ-025 The buffer SHALL be a register array of DEPTH x LEN bits, read combinationally by rd; it needs no reset.
REQ-026 err SHALL be sticky and SHALL be cleared only by rst.

Reset
REQ-027 When rst=1, the following SHALL hold immediately, independent of clk:
- state=LOAD; cnt, rd and len = 0; max = -2^(LEN-1);
- out_valid=0, out_angle=0, out_last=0, err=0;
- in_ready=0 while rst is held.
REQ-028 After rst deasserts, in_ready SHALL be 1 on the first clock cycle.
REQ-029 An rst asserted mid-LOAD or mid-EMIT SHALL abandon the vector; no partial output SHALL follow reset.

Verification
REQ-030 Input 3, -5, 7, 0 (last on 0), out_ready=1 -> out_angle -4, -12, 0, -7 on four consecutive cycles starting the cycle after the last input; out_last only on -7.
REQ-031 Input -32768, 32767 (last) -> out_angle -32768 (saturated from -65535), then 0; out_last on the second beat.
REQ-032 Input a single beat 1234 with last -> one output of 0 with out_last=1; in_ready=1 again the cycle after that transfer.
REQ-033 Input 0..3 with last, and out_ready toggling 1,0,0,1 each cycle -> out_angle holds its value during stalls; the outputs read -3, -2, -1, 0; no beat is dropped or duplicated.
REQ-034 With DEPTH=16, present 20 beats without last -> 16 beats are accepted, err=1, in_ready=0 during EMIT, 16 outputs follow with out_last on the 16th, and err stays 1 after return to LOAD.
REQ-035 Assert rst during EMIT after 2 of 4 outputs -> out_valid=0 immediately; a fresh vector 5, 5 (last) then yields 0, 0 with err=0.

Source files
------------

// File: rtl/softmax_max_subtract.sv
// -----------------------------------------------------------------------------
// softmax_max_subtract
//
// First stage of a numerically stable softmax. A vector of signed scores is
// buffered while its maximum is tracked. The block then replays the buffer,
// emitting (element - max) for each entry. Every emitted value is <= 0. A
// value that does not fit in LEN bits is clamped to the most negative code.
//
// The block alternates between two phases:
//   LOAD : accept input beats, store them, update the running max
//   EMIT : stream out the max-subtracted values, then go back to LOAD
//
// Ports
//   clk        in   1     single clock, rising edge
//   rst        in   1     asynchronous active-high reset
//   in_valid   in   1     input beat valid
//   in_ready   out  1     input beat accepted (LOAD only, low while in reset)
//   in_data    in   LEN   signed score element
//   in_last    in   1     final element of the vector
//   out_valid  out  1     output beat valid (EMIT only)
//   out_ready  in   1     downstream accepts the output beat
//   out_angle  out  LEN   saturated (element - vector max), always <= 0
//   out_last   out  1     final output element of the vector
//   err        out  1     sticky: a vector was truncated at DEPTH elements
// -----------------------------------------------------------------------------
module softmax_max_subtract #(
  parameter int LEN   = 16,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [LEN-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [LEN-1:0] out_angle,
  output logic                  out_last,
  output logic                  err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AWP = AW + 1;
  localparam logic signed [LEN-1:0] MIN_VAL = {1'b1, {(LEN-1){1'b0}}};

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [AW-1:0]         r_cnt;
  logic [AW-1:0]         r_rd;
  logic [AW:0]           r_len;   // one bit wider than cnt so it can hold DEPTH
  logic signed [LEN-1:0] r_max;
  logic                  r_err;
  logic signed [LEN-1:0] r_buf [DEPTH];

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_full;
  logic                  w_in_end;
  logic                  w_rd_last;
  logic signed [LEN-1:0] w_max_upd;
  logic signed [LEN-1:0] w_elem;
  logic signed [LEN:0]   w_diff;
  logic signed [LEN-1:0] w_angle;

  // ---------------------------------------------------------------------------
  // Handshakes and combinational datapath
  // ---------------------------------------------------------------------------
  // in_ready is gated by rst directly so no beat can be taken while reset is held.
  assign in_ready   = (r_state == ST_LOAD) && !rst;
  assign out_valid  = (r_state == ST_EMIT);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // A beat landing in the last buffer slot closes the vector even without in_last.
  assign w_full    = (r_cnt == AW'(DEPTH - 1));
  assign w_in_end  = in_last || w_full;

  // The beat being accepted takes part in the compare, so the max registered on
  // the last beat is already the true vector max.
  assign w_max_upd = (in_data > r_max) ? in_data : r_max;

  // Subtract at LEN+1 bits. The element is never above the max, so the only
  // possible overflow is on the negative side. It shows up as the two top bits
  // differing.
  assign w_elem  = r_buf[r_rd];
  assign w_diff  = {w_elem[LEN-1], w_elem} - {r_max[LEN-1], r_max};
  assign w_angle = (w_diff[LEN] != w_diff[LEN-1]) ? MIN_VAL : w_diff[LEN-1:0];

  assign w_rd_last = ({1'b0, r_rd} == (r_len - AWP'(1)));

  // Outputs read as zero outside EMIT, and therefore immediately in reset.
  assign out_angle = out_valid ? w_angle : '0;
  assign out_last  = out_valid && w_rd_last;
  assign err       = r_err;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_in_fire && w_in_end) begin
          w_state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_out_fire && w_rd_last) begin
          w_state_next = ST_LOAD;
        end
      end
      default: w_state_next = ST_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters, running max, sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_rd  <= '0;
      r_len <= '0;
      r_max <= MIN_VAL;
      r_err <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_max <= w_max_upd;
        if (w_in_end) begin
          r_len <= {1'b0, r_cnt} + AWP'(1);
          r_rd  <= '0;
          if (!in_last) begin
            r_err <= 1'b1;   // vector truncated at DEPTH
          end
        end else begin
          r_cnt <= r_cnt + AW'(1);
        end
      end
      if (w_out_fire) begin
        if (w_rd_last) begin
          r_cnt <= '0;
          r_rd  <= '0;
          r_max <= MIN_VAL;
        end else begin
          r_rd  <= r_rd + AW'(1);
        end
      end
    end
  end

  // Element buffer. It has no reset because it is only read at indices that
  // were written during the current vector.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_buf[r_cnt] <= in_data;
    end
  end

endmodule

// File: tb/tb_softmax_max_subtract.sv
// -----------------------------------------------------------------------------
// tb_softmax_max_subtract
//
// Self-checking bench for softmax_max_subtract (LEN=16, DEPTH=16).
// Each vector is driven in through the input handshake. Expected outputs come
// from a plain-arithmetic reference: the max of the accepted elements, then
// element minus max, clamped to -32768. The bench checks the latency, the
// holding of outputs during stalls, last flags, handshakes and the sticky
// error flag.
// -----------------------------------------------------------------------------
module tb_softmax_max_subtract;

  localparam int LEN   = 16;
  localparam int DEPTH = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic signed [LEN-1:0] in_data = '0;
  logic                  in_last = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic signed [LEN-1:0] out_angle;
  logic                  out_last;
  logic                  err;

  int n_checks = 0;
  int n_fail   = 0;
  bit err_exp  = 1'b0;
  int vec   [64];
  int exp_q [DEPTH];

  softmax_max_subtract #(.LEN(LEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_angle (out_angle),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Drive vec[0..n-1] in, then collect the outputs and compare them with the model.
  // mode: 0 = out_ready always 1, 1 = pattern 1,0,0,1, 2 = random.
  // nolast: never raise in_last (overflow case); extra beats stay offered during EMIT.
  // abort_after >= 0: stop collecting after that many outputs (for reset tests).
  task automatic run_vector(input string tag, input int n, input int mode,
                            input bit nolast, input int abort_after);
    int  acc;
    int  cyc;
    int  m;
    int  k;
    int  pc;
    int  mx;
    int  d;
    bit  done;
    bit  rdy;
    bit  ordy;
    bit  prev_stall;
    logic signed [LEN-1:0] pa;
    logic                  pl;
    acc = 0; cyc = 0; done = 1'b0;
    // ---- load phase ----
    while (!done) begin
      in_valid = 1'b1;
      in_data  = LEN'(vec[acc]);
      in_last  = !nolast && (acc == n - 1);
      #1;
      rdy = in_ready;
      n_checks++;
      if (rdy !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s load_handshake beat %0d: in_ready=%b out_valid=%b, required 1/0",
                 tag, acc, rdy, out_valid);
      end
      @(posedge clk); #1;
      if (rdy) begin
        acc++;
        if (in_last) done = 1'b1;
        else if (acc == DEPTH) begin
          done = 1'b1;
          err_exp = 1'b1;   // truncated vector
        end
      end
      cyc++;
      if (cyc > 100 && !done) begin
        n_checks++; n_fail++;
        $display("FAIL %s load_timeout: accepted %0d beats, required %0d", tag, acc, n);
        done = 1'b1;
      end
    end
    // ---- reference model ----
    m  = acc;
    mx = vec[0];
    for (int i = 1; i < m; i++) if (vec[i] > mx) mx = vec[i];
    for (int i = 0; i < m; i++) begin
      d = vec[i] - mx;
      if (d < -32768) d = -32768;
      exp_q[i] = d;
    end
    if (nolast) begin
      in_valid = 1'b1; in_last = 1'b0; in_data = LEN'(vec[acc]);
    end else begin
      in_valid = 1'b0; in_last = 1'b0;
    end
    // ---- emit phase ----
    k = 0; cyc = 0; pc = 0; prev_stall = 1'b0; pa = '0; pl = 1'b0;
    while (k < m) begin
      if (abort_after >= 0 && k == abort_after) break;
      if (mode == 0)      ordy = 1'b1;
      else if (mode == 1) ordy = ((pc % 4) == 0) || ((pc % 4) == 3);
      else                ordy = 1'($urandom_range(0, 1));
      pc++;
      out_ready = ordy;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s emit_handshake out %0d: out_valid=%b in_ready=%b, required 1/0",
                 tag, k, out_valid, in_ready);
      end
      if (prev_stall) begin
        n_checks++;
        if (out_angle !== pa || out_last !== pl) begin
          n_fail++;
          $display("FAIL %s stall_hold out %0d: angle=%0d last=%b, required %0d/%b",
                   tag, k, out_angle, out_last, pa, pl);
        end
      end
      if (ordy) begin
        n_checks++;
        if (int'(out_angle) !== exp_q[k] || out_last !== (k == m - 1)) begin
          n_fail++;
          $display("FAIL %s out_angle[%0d]: angle=%0d last=%b, required %0d/%b",
                   tag, k, out_angle, out_last, exp_q[k], (k == m - 1));
        end
        k++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        pa = out_angle;
        pl = out_last;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 500 && k < m) begin
        n_checks++; n_fail++;
        $display("FAIL %s emit_timeout: got %0d outputs, required %0d", tag, k, m);
        break;
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    if (abort_after < 0) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== err_exp) begin
        n_fail++;
        $display("FAIL %s after_vector: out_valid=%b in_ready=%b err=%b, required 0/1/%b",
                 tag, out_valid, in_ready, err, err_exp);
      end
    end
    $display("vector %s: %0d in, %0d accepted, max %0d", tag, n, m, mx);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;   // no clock edge yet: reset must act on its own
    n_checks++;
    if (out_valid !== 1'b0 || out_angle !== '0 || out_last !== 1'b0 ||
        err !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b angle=%0d last=%b err=%b in_ready=%b, required all 0",
               out_valid, out_angle, out_last, err, in_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    $display("reset: done");
  endtask

  task automatic test_basic();
    vec[0] = 3; vec[1] = -5; vec[2] = 7; vec[3] = 0;
    run_vector("basic", 4, 0, 1'b0, -1);
  endtask

  task automatic test_saturation();
    vec[0] = -32768; vec[1] = 32767;
    run_vector("saturation", 2, 0, 1'b0, -1);
  endtask

  task automatic test_single();
    vec[0] = 1234;
    run_vector("single", 1, 0, 1'b0, -1);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) vec[i] = i;
    run_vector("stall", 4, 1, 1'b0, -1);
  endtask

  task automatic test_equal();
    for (int i = 0; i < 5; i++) vec[i] = -77;
    run_vector("equal", 5, 1, 1'b0, -1);
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 5))
          0:       vec[i] = -32768;
          1:       vec[i] = 32767;
          default: vec[i] = int'($signed(16'($urandom)));
        endcase
      end
      run_vector($sformatf("random%0d", t), n, 2, 1'b0, -1);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++) vec[i] = int'($signed(16'($urandom_range(0, 4000)))) - 2000;
    run_vector("overflow", 20, 0, 1'b1, -1);
    vec[0] = 1; vec[1] = -1;
    run_vector("after_overflow", 2, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_emit();
    n_checks++;
    if (err !== err_exp) begin
      n_fail++;
      $display("FAIL sticky_err_before_reset: err=%b, required %b", err, err_exp);
    end
    vec[0] = 1; vec[1] = 2; vec[2] = 3; vec[3] = 4;
    run_vector("abort", 4, 0, 1'b0, 2);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre_reset: out_valid=%b, required 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_angle !== '0 || out_last !== 1'b0 ||
        err !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_emit: out_valid=%b angle=%0d last=%b err=%b in_ready=%b, required all 0",
               out_valid, out_angle, out_last, err, in_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    err_exp = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_emit_release: in_ready=%b out_valid=%b, required 1/0",
               in_ready, out_valid);
    end
    vec[0] = 5; vec[1] = 5;
    run_vector("fresh", 2, 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_single();
    test_stall();
    test_equal();
    test_random();
    test_overflow();
    test_reset_mid_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
